e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
Multiply/divide sequencer for the E stage. It owns the HI/LO architectural registers and runs mult/multu/div/divu (and mthi/mtlo) as a multi-cycle resource beside the ALU. It publishes busy and a stall request to the hazard/stall logic, so the D stage holds any HI/LO-touching instruction while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  E-stage MDU instruction valid this cycle (one-cycle pulse per instruction)
md_op  in  4  operation code (package constants)
src_a  in  32  forwarded rs value from E
src_b  in  32  forwarded rt value from E
d_is_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo (or madd family)
busy  out  1  operation in flight
stall_req  out  1  to stall unit: hold F/D, bubble E
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (reset==0, async): state IDLE, counter=0, busy=0, hi=0, lo=0. Any in-flight operation is aborted with no commit.
- States: IDLE, RUN.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - Latch src_a and src_b; compute the result into shadow registers at edge k.
  - Load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES); go to RUN.
  - busy=1 for exactly N cycles after edge k.
- RUN: counter decrements each edge. On the edge where counter==0:
  - Commit shadow to hi/lo.
  - busy falls and the state returns to IDLE on the same edge.
  - hi/lo are visible to mfhi/mflo in the following cycle.
- Arithmetic:
  - MULT: signed 32x32->64; hi=upper 32 bits, lo=lower 32 bits.
  - MULTU: unsigned 32x32->64; same split.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - 0x80000000 / -1: lo=0x80000000, hi=0.
- Divide by zero: runs the full DIV_CYCLES; hi/lo are left unchanged at commit.
- MTHI/MTLO with start=1 in IDLE: write hi (or lo) from src_a at the next edge. No busy cycle; the other register is unchanged.
- start=1 while busy: ignored, no state change; the bench flags it as a protocol error. It cannot occur legally because stall_req prevents it.
- Unknown md_op with start=1: ignored.
- stall_req = d_is_md & (start | busy). This is combinational with no registered delay, so the cycle in which start is high already stalls a following MDU instruction.
- hi/lo outputs are registered; they never change mid-operation.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined: MADD, MADDU, MSUB and MSUBU are accepted.
  - MADD/MADDU: {hi,lo} +/- product, signed/unsigned respectively; MSUB/MSUBU likewise.
  - The accumulate uses the {hi,lo} value at the commit edge, wraps modulo 2^64, and takes MULT_CYCLES.
- When not defined: those codes are treated as unknown and ignored, and no 64-bit adder is synthesised.

Decomposition:
- Shared package/header holds:
  - md_op constants: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MADD=7, MD_MADDU=8, MD_MSUB=9, MD_MSUBU=10.
  - State encodings: IDLE=0, RUN=1.
  - Default cycle counts.
- The CU decodes md_op and d_is_md using the same constants.
- One natural sub-module, e_mdu_calc: purely combinational 64-bit result generation (mult/div/accumulate) from op, a, b, {hi,lo}. e_mdu keeps the FSM, counter and registers.

Test Plan:
- Reset, then start MULT with a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0 on the 6th cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles; DIVU 7/0 with prior hi=0x11, lo=0x22 -> still 0x11/0x22 after 10 cycles.
- start DIV with d_is_md=1 held -> stall_req=1 in the start cycle and all 10 busy cycles, 0 on the first idle cycle. A second start pulse mid-run leaves hi/lo and the counter undisturbed.
- MTHI src_a=0x12345678 -> hi=0x12345678 next cycle, busy never asserts, lo unchanged.
- MULT in flight, reset pulled low at busy cycle 3 -> hi=lo=0 and busy=0 immediately (async). With MDU_MADD_EN, hi:lo=0:5 then MADD 2x3 -> lo=0x0B after 5 cycles.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// e_mdu shared constants: md_op codes, FSM states, default cycle counts.
// MDU_MADD_EN enables the multiply-accumulate op family.
package e_mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that occupy the unit for multiple cycles.
  function automatic logic md_is_long(input logic [3:0] op);
    logic v;
    v = (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
`ifdef MDU_MADD_EN
    v = v || (op == MD_MADD) || (op == MD_MADDU) ||
         (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return v;
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// e_mdu_calc: combinational 64-bit {hi,lo} result for mult/div/accumulate.
// Accumulate ops exist only when MDU_MADD_EN is defined.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [63:0] i_acc,
  output logic [63:0] o_res
);

  logic [63:0] w_sa;
  logic [63:0] w_sb;
  logic [63:0] w_ua;
  logic [63:0] w_ub;
  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic signed [31:0] w_as;
  logic signed [31:0] w_bs;
  logic signed [31:0] w_sqd;
  logic signed [31:0] w_srd;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic w_bz;
  logic w_ovf;

  assign w_sa = {{32{i_a[31]}}, i_a};
  assign w_sb = {{32{i_b[31]}}, i_b};
  assign w_ua = {32'd0, i_a};
  assign w_ub = {32'd0, i_b};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = w_ua * w_ub;

  assign w_as  = i_a;
  assign w_bs  = i_b;
  assign w_bz  = (i_b == 32'd0);
  assign w_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  assign w_sqd = w_bz ? 32'sd0 : w_as / w_bs;
  assign w_srd = w_bz ? 32'sd0 : w_as % w_bs;
  assign w_sq  = w_ovf ? 32'h8000_0000 : w_sqd;
  assign w_sr  = w_ovf ? 32'd0 : w_srd;
  assign w_uq  = w_bz ? 32'd0 : i_a / i_b;
  assign w_ur  = w_bz ? 32'd0 : i_a % i_b;

  // Divide by zero returns the accumulator so commit leaves hi/lo as is.
  always_comb begin
    o_res = i_acc;
    case (i_op)
      MD_MULT:  o_res = w_sprod;
      MD_MULTU: o_res = w_uprod;
      MD_DIV:   if (!w_bz) o_res = {w_sr, w_sq};
      MD_DIVU:  if (!w_bz) o_res = {w_ur, w_uq};
`ifdef MDU_MADD_EN
      MD_MADD:  o_res = i_acc + w_sprod;
      MD_MADDU: o_res = i_acc + w_uprod;
      MD_MSUB:  o_res = i_acc - w_sprod;
      MD_MSUBU: o_res = i_acc - w_uprod;
`endif
      default:  o_res = i_acc;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide sequencer owning HI/LO; build option
// MDU_MADD_EN adds madd/maddu/msub/msubu.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] LD_MUL = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_DIV = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e r_state;
  mdu_state_e w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] w_res;
  logic w_idle;
  logic w_go;
  logic w_mthi;
  logic w_mtlo;
  logic w_commit;

  assign w_idle = (r_state == IDLE);
  assign w_go   = start & w_idle & md_is_long(md_op);
  assign w_mthi = start & w_idle & (md_op == MD_MTHI);
  assign w_mtlo = start & w_idle & (md_op == MD_MTLO);

  e_mdu_calc u_calc (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .i_acc ({r_hi, r_lo}),
    .o_res (w_res)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_go) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = md_is_div(md_op) ? LD_DIV : LD_MUL;
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op <= MD_NONE;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_go) begin
      r_op <= md_op;
      r_a  <= src_a;
      r_b  <= src_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_res[63:32];
      r_lo <= w_res[31:0];
    end else if (w_mthi) begin
      r_hi <= src_a;
    end else if (w_mtlo) begin
      r_lo <= src_a;
    end
  end

  assign busy      = (r_state == RUN);
  assign stall_req = d_is_md & (start | busy);
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed vectors for e_mdu with hand-computed results.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_is_md;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  e_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .d_is_md   (d_is_md),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    md_op = MD_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input int cyc, input logic [31:0] ehi,
                     input logic [31:0] elo);
    int n;
    pulse(op, a, b);
    wait_idle(n);
    chk({tag, "_cyc"}, n, cyc);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    reset = 1'b0;
    start = 1'b0;
    md_op = MD_NONE;
    src_a = '0;
    src_b = '0;
    d_is_md = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    run("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5,
        32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
        32'hFFFF_FFFE, 32'h0000_0001);
    run("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_nd", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10,
        32'd1, 32'hFFFF_FFFD);
    run("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 10,
        32'd1, 32'h7FFF_FFFC);
    run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
        32'd0, 32'h8000_0000);

    pulse(MD_MTHI, 32'h11, 32'd0);
    pulse(MD_MTLO, 32'h22, 32'd0);
    run("divu_z", MD_DIVU, 32'd7, 32'd0, 10, 32'h11, 32'h22);

    // Stall window plus a stray start mid-run.
    d_is_md = 1'b1;
    start = 1'b1;
    md_op = MD_DIV;
    src_a = 32'd100;
    src_b = 32'd7;
    #1;
    chk("stall_start", {31'd0, stall_req}, 32'd1);
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      chk("stall_busy", {31'd0, stall_req}, 32'd1);
      if (n == 3) begin
        start = 1'b1;
        md_op = MD_MULT;
        src_a = 32'd5;
        src_b = 32'd5;
      end
      n++;
      tick();
      start = 1'b0;
    end
    chk("stall_cyc", n, 32'd10);
    chk("stall_idle", {31'd0, stall_req}, 32'd0);
    chk("stall_hi", hi, 32'd2);
    chk("stall_lo", lo, 32'd14);
    d_is_md = 1'b0;

    pulse(MD_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'd14);

    pulse(4'hF, 32'hDEAD_BEEF, 32'd1);
    chk("unk_busy", {31'd0, busy}, 32'd0);
    chk("unk_hi", hi, 32'h1234_5678);
    chk("unk_lo", lo, 32'd14);

    pulse(MD_MULT, 32'd3, 32'd4);
    tick();
    tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    tick();

`ifdef MDU_MADD_EN
    pulse(MD_MTLO, 32'd5, 32'd0);
    run("madd", MD_MADD, 32'd2, 32'd3, 5, 32'd0, 32'h0000_000B);
    run("msubu", MD_MSUBU, 32'd12, 32'd1, 5,
        32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    pulse(MD_MADD, 32'd2, 32'd3);
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    chk("madd_off_lo", lo, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
